// File: rtl/breakout_to_host_ser_if.sv
// Host-side payload handshake for the breakout serializer: parallel words in,
// holding-register-empty indication back out.
interface breakout_to_host_ser_if #(
  parameter int LANES        = 2,
  parameter int PAYLOAD_BITS = 8
);
  logic [LANES*PAYLOAD_BITS-1:0] i_data;
  logic                          i_valid;
  logic                          o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/breakout_to_host_ser.sv
// Packs LANES payload words into fixed-length frames (payload, even parity, toggle)
// and emits two bits per lane per clock for DDR output cells; repeats on starvation.
module breakout_to_host_ser #(
  parameter int LANES        = 2,
  parameter int PAYLOAD_BITS = 8,
  parameter int CNT_W        = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  breakout_to_host_ser_if.slave  host,
  output logic                   o_clk_first,
  output logic                   o_clk_second,
  output logic [LANES-1:0]       o_dat_first,
  output logic [LANES-1:0]       o_dat_second,
  output logic                   o_frame_start,
  output logic [CNT_W-1:0]       o_underrun_cnt
);
  localparam int FRAME_BITS = PAYLOAD_BITS + 2;
  localparam int BEATS      = FRAME_BITS / 2;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int WORD_W     = LANES * PAYLOAD_BITS;
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [FRAME_BITS-1:0] CLK_FRAME = {{BEATS{1'b1}}, {BEATS{1'b0}}};

  logic [BEAT_W-1:0]                beat_q;
  logic [WORD_W-1:0]                hold_data_q;
  logic                             hold_valid_q;
  logic                             ready_q;
  logic [WORD_W-1:0]                last_word_q;
  logic                             toggle_q;
  logic [CNT_W-1:0]                 underrun_q;
  logic [LANES-1:0][FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0]            clk_shift_q;

  logic                             load;
  logic                             xfer;
  logic [BEAT_W-1:0]                beat_d;
  logic [WORD_W-1:0]                word_d;
  logic                             toggle_d;
  logic                             hold_valid_d;
  logic [PAYLOAD_BITS-1:0]          lane_word;
  logic [LANES-1:0][FRAME_BITS-1:0] frame_d;
  logic [LANES-1:0][FRAME_BITS-1:0] lane_src;
  logic [FRAME_BITS-1:0]            clk_src;

  // The edge ending the last beat loads a new frame; frame bit 0 sits in the MSB
  // of each shift register so the outputs always take the top two bits.
  always_comb begin
    load         = (beat_q == LAST_BEAT);
    xfer         = host.i_valid & ready_q;
    beat_d       = load ? '0 : beat_q + 1'b1;
    word_d       = last_word_q;
    toggle_d     = toggle_q;
    if (load && hold_valid_q) begin
      word_d   = hold_data_q;
      toggle_d = ~toggle_q;
    end
    hold_valid_d = hold_valid_q;
    if (load) hold_valid_d = 1'b0;
    if (xfer) hold_valid_d = 1'b1;
    lane_word = '0;
    frame_d   = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_word  = word_d[l*PAYLOAD_BITS +: PAYLOAD_BITS];
      frame_d[l] = {lane_word, ^lane_word, toggle_d};
    end
    lane_src = load ? frame_d : shift_q;
    clk_src  = load ? CLK_FRAME : clk_shift_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      beat_q        <= LAST_BEAT;
      hold_data_q   <= '0;
      hold_valid_q  <= 1'b0;
      ready_q       <= 1'b0;
      last_word_q   <= '0;
      toggle_q      <= 1'b0;
      underrun_q    <= '0;
      shift_q       <= '0;
      clk_shift_q   <= '0;
      o_clk_first   <= 1'b0;
      o_clk_second  <= 1'b0;
      o_dat_first   <= '0;
      o_dat_second  <= '0;
      o_frame_start <= 1'b0;
    end else begin
      beat_q <= beat_d;
      if (load) begin
        last_word_q <= word_d;
        toggle_q    <= toggle_d;
        if (!hold_valid_q && (underrun_q != '1)) underrun_q <= underrun_q + 1'b1;
      end
      // A word accepted on a load edge was not part of that load; it waits a frame.
      if (xfer) hold_data_q <= host.i_data;
      hold_valid_q  <= hold_valid_d;
      ready_q       <= ~hold_valid_d;
      clk_shift_q   <= clk_src << 2;
      o_clk_first   <= clk_src[FRAME_BITS-1];
      o_clk_second  <= clk_src[FRAME_BITS-2];
      for (int l = 0; l < LANES; l++) begin
        shift_q[l]      <= lane_src[l] << 2;
        o_dat_first[l]  <= lane_src[l][FRAME_BITS-1];
        o_dat_second[l] <= lane_src[l][FRAME_BITS-2];
      end
      o_frame_start <= load;
    end
  end

  assign host.o_ready   = ready_q;
  assign o_underrun_cnt = underrun_q;

endmodule

// File: tb/tb_breakout_to_host_ser.sv
// Scoreboard bench: default 2-lane instance for handshake/starvation/reset scenarios,
// a 4-lane 6-bit instance for parity, clock pattern and counter saturation.
module tb_breakout_to_host_ser;
  localparam int BEATS2 = 5;
  localparam int BEATS4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst4_n;

  breakout_to_host_ser_if #(.LANES(2), .PAYLOAD_BITS(8)) bus ();
  breakout_to_host_ser_if #(.LANES(4), .PAYLOAD_BITS(6)) bus4 ();

  logic        clk_first, clk_second, frame_start;
  logic [1:0]  dat_first, dat_second;
  logic [15:0] underrun_cnt;
  logic        clk4_first, clk4_second, frame4_start;
  logic [3:0]  dat4_first, dat4_second;
  logic [15:0] underrun4_cnt;

  breakout_to_host_ser #(.LANES(2), .PAYLOAD_BITS(8), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .host(bus),
    .o_clk_first(clk_first), .o_clk_second(clk_second),
    .o_dat_first(dat_first), .o_dat_second(dat_second),
    .o_frame_start(frame_start), .o_underrun_cnt(underrun_cnt)
  );

  breakout_to_host_ser #(.LANES(4), .PAYLOAD_BITS(6), .CNT_W(16)) dut4 (
    .i_clk(clk), .i_rst_n(rst4_n), .host(bus4),
    .o_clk_first(clk4_first), .o_clk_second(clk4_second),
    .o_dat_first(dat4_first), .o_dat_second(dat4_second),
    .o_frame_start(frame4_start), .o_underrun_cnt(underrun4_cnt)
  );

  int total = 0;
  int bad = 0;
  logic        m_toggle;
  logic [15:0] m_cnt;
  logic [19:0] exp_q[$];
  logic [31:0] exp4_q[$];

  // Expected lane stream, first bit in the MSB: payload MSB..LSB, even parity, toggle.
  function automatic logic [19:0] exp_frame2(input logic [15:0] w, input logic t);
    return {w[15:8], ^w[15:8], t, w[7:0], ^w[7:0], t};
  endfunction

  function automatic logic [31:0] exp_frame4(input logic [23:0] w, input logic t);
    logic [3:0][7:0] r;
    logic [5:0]      p;
    for (int l = 0; l < 4; l++) begin
      p    = w[l*6 +: 6];
      r[l] = {p, ^p, t};
    end
    return r;
  endfunction

  task automatic wait_frame_start(input string tag);
    bit ok = 0;
    for (int i = 0; i < 3*BEATS2 && !ok; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) ok = 1;
    end
    if (!ok) begin
      total++; bad++;
      $display("[TB] FAIL %s: frame_start not seen within %0d cycles", tag, 3*BEATS2);
    end
  endtask

  task automatic capture2(input string tag, output logic [19:0] f, output logic [9:0] ck);
    f  = '0;
    ck = '0;
    wait_frame_start(tag);
    for (int b = 0; b < BEATS2; b++) begin
      if (b > 0) @(negedge clk);
      ck       = {ck[7:0], clk_first, clk_second};
      f[9:0]   = {f[7:0], dat_first[0], dat_second[0]};
      f[19:10] = {f[17:10], dat_first[1], dat_second[1]};
    end
  endtask

  task automatic capture4(input string tag, output logic [3:0][7:0] f, output logic [7:0] ck);
    bit ok = 0;
    f  = '0;
    ck = '0;
    for (int i = 0; i < 3*BEATS4 && !ok; i++) begin
      @(negedge clk);
      if (frame4_start === 1'b1) ok = 1;
    end
    if (!ok) begin
      total++; bad++;
      $display("[TB] FAIL %s: frame_start not seen", tag);
    end
    for (int b = 0; b < BEATS4; b++) begin
      if (b > 0) @(negedge clk);
      ck = {ck[5:0], clk4_first, clk4_second};
      for (int l = 0; l < 4; l++) f[l] = {f[l][5:0], dat4_first[l], dat4_second[l]};
    end
  endtask

  task automatic reset_sequence(input string tag);
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({clk_first, clk_second, dat_first, dat_second, frame_start, underrun_cnt, bus.o_ready} !== 24'h0) begin
        bad++;
        $display("[TB] FAIL %s_outputs_zero: got %h want 0", tag,
                 {clk_first, clk_second, dat_first, dat_second, frame_start, underrun_cnt, bus.o_ready});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (frame_start !== 1'b1) begin bad++; $display("[TB] FAIL %s_frame_start: got %b want 1", tag, frame_start); end
    total++;
    if ({clk_first, clk_second} !== 2'b11) begin bad++; $display("[TB] FAIL %s_clk_pair: got %b want 11", tag, {clk_first, clk_second}); end
    total++;
    if (bus.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL %s_ready: got %b want 1", tag, bus.o_ready); end
    total++;
    if (underrun_cnt !== 16'd1) begin bad++; $display("[TB] FAIL %s_underrun: got %0d want 1", tag, underrun_cnt); end
    total++;
    if ({dat_first, dat_second} !== 4'b0) begin bad++; $display("[TB] FAIL %s_dat_zero: got %b want 0000", tag, {dat_first, dat_second}); end
    m_toggle = 1'b0;
    m_cnt    = 16'd1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_sequence("reset");
  endtask

  task automatic test_single_word();
    logic [19:0] f, e;
    logic [9:0]  ck;
    bus.i_data  = {8'h3C, 8'hA5};
    bus.i_valid = 1'b1;
    m_toggle    = ~m_toggle;
    exp_q.push_back(exp_frame2(16'h3CA5, m_toggle));
    @(negedge clk);
    bus.i_valid = 1'b0;
    total++;
    if (bus.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL single_ready_drop: got %b want 0", bus.o_ready); end
    capture2("single", f, ck);
    e = exp_q.pop_front();
    total++;
    if (f !== e) begin bad++; $display("[TB] FAIL single_frame: got %b want %b", f, e); end
    total++;
    if (f[9:0] !== 10'b1010010101) begin bad++; $display("[TB] FAIL single_lane0: got %b want 1010010101", f[9:0]); end
    total++;
    if (f[19:10] !== 10'b0011110001) begin bad++; $display("[TB] FAIL single_lane1: got %b want 0011110001", f[19:10]); end
    total++;
    if (ck !== 10'b1111100000) begin bad++; $display("[TB] FAIL single_clk: got %b want 1111100000", ck); end
    total++;
    if (underrun_cnt !== m_cnt) begin bad++; $display("[TB] FAIL single_underrun: got %0d want %0d", underrun_cnt, m_cnt); end
    total++;
    if (bus.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready_back: got %b want 1", bus.o_ready); end
  endtask

  task automatic test_starvation();
    logic [19:0] f, e;
    logic [9:0]  ck;
    for (int n = 0; n < 2; n++) begin
      exp_q.push_back(exp_frame2(16'h3CA5, m_toggle));
      m_cnt++;
      capture2("starve", f, ck);
      e = exp_q.pop_front();
      total++;
      if (f !== e) begin bad++; $display("[TB] FAIL starve_frame%0d: got %b want %b", n, f, e); end
      total++;
      if (underrun_cnt !== m_cnt) begin bad++; $display("[TB] FAIL starve_underrun%0d: got %0d want %0d", n, underrun_cnt, m_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w [3];
    logic [19:0] f, e;
    logic [9:0]  ck;
    w[0] = 16'h1E81;
    w[1] = 16'h7F00;
    w[2] = 16'hC35A;
    wait_frame_start("bp_sync");
    m_cnt++;
    bus.i_data  = w[0];
    bus.i_valid = 1'b1;
    @(negedge clk);
    total++;
    if (bus.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready_drop0: got %b want 0", bus.o_ready); end
    bus.i_data = w[1];
    for (int i = 0; i < 3; i++) begin
      m_toggle = ~m_toggle;
      exp_q.push_back(exp_frame2(w[i], m_toggle));
      capture2("bp", f, ck);
      e = exp_q.pop_front();
      total++;
      if (f !== e) begin bad++; $display("[TB] FAIL bp_frame%0d: got %b want %b", i, f, e); end
      total++;
      if (underrun_cnt !== m_cnt) begin bad++; $display("[TB] FAIL bp_underrun%0d: got %0d want %0d", i, underrun_cnt, m_cnt); end
      total++;
      if (bus.o_ready !== (i == 2)) begin bad++; $display("[TB] FAIL bp_ready%0d: got %b want %b", i, bus.o_ready, (i == 2)); end
      if (i == 0) bus.i_data = w[2];
      if (i == 1) bus.i_valid = 1'b0;
    end
    // Nothing left: the last word repeats without a toggle flip.
    exp_q.push_back(exp_frame2(w[2], m_toggle));
    m_cnt++;
    capture2("bp_repeat", f, ck);
    e = exp_q.pop_front();
    total++;
    if (f !== e) begin bad++; $display("[TB] FAIL bp_repeat_frame: got %b want %b", f, e); end
    total++;
    if (underrun_cnt !== m_cnt) begin bad++; $display("[TB] FAIL bp_repeat_underrun: got %0d want %0d", underrun_cnt, m_cnt); end
  endtask

  task automatic test_mid_frame_reset();
    logic [19:0] f, e;
    logic [9:0]  ck;
    wait_frame_start("mid_sync");
    bus.i_data  = 16'h5AF0;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    total++;
    if (bus.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_held: got %b want 0", bus.o_ready); end
    @(negedge clk);
    reset_sequence("midreset");
    exp_q.push_back(exp_frame2(16'h0000, 1'b0));
    m_cnt++;
    capture2("mid_after", f, ck);
    e = exp_q.pop_front();
    total++;
    if (f !== e) begin bad++; $display("[TB] FAIL mid_discard_frame: got %b want %b", f, e); end
    total++;
    if (underrun_cnt !== m_cnt) begin bad++; $display("[TB] FAIL mid_underrun: got %0d want %0d", underrun_cnt, m_cnt); end
  endtask

  task automatic test_param4();
    logic [3:0][7:0] f;
    logic [31:0]     e;
    logic [7:0]      ck;
    bus4.i_valid = 1'b0;
    bus4.i_data  = '0;
    @(negedge clk);
    total++;
    if ({clk4_first, clk4_second, dat4_first, dat4_second, frame4_start, underrun4_cnt, bus4.o_ready} !== 28'h0) begin
      bad++;
      $display("[TB] FAIL p4_reset_zero: got %h want 0",
               {clk4_first, clk4_second, dat4_first, dat4_second, frame4_start, underrun4_cnt, bus4.o_ready});
    end
    rst4_n = 1'b1;
    @(negedge clk);
    total++;
    if ({frame4_start, clk4_first, clk4_second, bus4.o_ready} !== 4'b1111) begin
      bad++; $display("[TB] FAIL p4_release: got %b want 1111", {frame4_start, clk4_first, clk4_second, bus4.o_ready});
    end
    bus4.i_data  = {6'h2A, 6'h00, 6'h01, 6'h3F};
    bus4.i_valid = 1'b1;
    exp4_q.push_back(exp_frame4({6'h2A, 6'h00, 6'h01, 6'h3F}, 1'b1));
    @(negedge clk);
    bus4.i_valid = 1'b0;
    capture4("p4", f, ck);
    e = exp4_q.pop_front();
    total++;
    if (f !== e) begin bad++; $display("[TB] FAIL p4_frame: got %h want %h", f, e); end
    total++;
    if (f !== 32'hAB0107FD) begin bad++; $display("[TB] FAIL p4_parity_lanes: got %h want ab0107fd", f); end
    total++;
    if (ck !== 8'b11110000) begin bad++; $display("[TB] FAIL p4_clk: got %b want 11110000", ck); end
    total++;
    if (underrun4_cnt !== 16'd1) begin bad++; $display("[TB] FAIL p4_underrun: got %0d want 1", underrun4_cnt); end
    force dut4.underrun_q = 16'hFFFE;
    repeat (2*BEATS4) @(negedge clk);
    release dut4.underrun_q;
    repeat (2*BEATS4) @(negedge clk);
    total++;
    if (underrun4_cnt !== 16'hFFFF) begin bad++; $display("[TB] FAIL p4_saturate: got %h want ffff", underrun4_cnt); end
    repeat (2*BEATS4) @(negedge clk);
    total++;
    if (underrun4_cnt !== 16'hFFFF) begin bad++; $display("[TB] FAIL p4_saturate_hold: got %h want ffff", underrun4_cnt); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    rst4_n       = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_data   = '0;
    bus4.i_valid = 1'b0;
    bus4.i_data  = '0;
    m_toggle     = 1'b0;
    m_cnt        = '0;
    $display("[TB] starting breakout_to_host_ser bench");
    test_reset();
    test_single_word();
    test_starvation();
    test_back_to_back();
    test_mid_frame_reset();
    test_param4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
